sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Shares the single external 16-bit SRAM between two requesters: the delay effect (port D) and the looper (port L).
- Replaces the valid-chained hand-over with a request/acknowledge arbiter. It uses round-robin priority, fixed access timing and a per-sample-frame overrun monitor.
- Sits in the top level between the effect modules and the SRAM pins, clocked by the audio bit clock.

Parameters:
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- ACC_CYCLES, 2, clock cycles the SRAM bus is held per access; legal range 1..15
- CNT_W, 8, overrun counter width

Ports:
- i_clk  in  1  audio bit clock (BCLK)
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse at the start of each sample frame
- i_clr_overrun  in  1  synchronous clear of o_overrun_cnt
- i_del_req  in  1  delay access request, level
- i_del_we_n  in  1  0 = write, 1 = read
- i_del_addr  in  ADDR_W  delay address
- i_del_wdata  in  DATA_W  delay write data
- o_del_ack  out  1  one-cycle completion pulse
- o_del_rdata  out  DATA_W  delay read data, registered
- i_loop_req, i_loop_we_n, i_loop_addr, i_loop_wdata, o_loop_ack, o_loop_rdata: same as the delay set, for the looper
- o_SRAM_ADDR  out  ADDR_W  SRAM address
- o_SRAM_WE_N  out  1  SRAM write enable, active low
- o_sram_dq_oe  out  1  1 = top level drives io_SRAM_DQ with o_sram_wdata
- o_sram_wdata  out  DATA_W  data to drive onto DQ
- i_sram_rdata  in  DATA_W  DQ read value
- o_busy  out  1  high whenever state != S_IDLE
- o_grant  out  2  one-hot owner: [0] = D, [1] = L; 00 when idle
- o_overrun_cnt  out  CNT_W  saturating count of frame overruns

Behaviour:
- Single clock i_clk; reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - state = S_IDLE
  - o_SRAM_WE_N = 1, o_sram_dq_oe = 0, o_SRAM_ADDR = 0, o_sram_wdata = 0
  - both acks = 0, both rdata = 0, o_grant = 00, o_overrun_cnt = 0
  - last_grant = L, so D wins the first tie
- State machine: S_IDLE -> S_ACCESS -> S_DONE -> S_IDLE.
- S_IDLE:
  - Only D requesting: grant D. Only L requesting: grant L. Both requesting: grant the port that is not last_grant.
  - On grant, latch the grantee's we_n, addr and wdata. Set last_grant to the grantee, load the cycle counter with ACC_CYCLES-1, then go to S_ACCESS.
  - No request: stay in S_IDLE.
  - Requests are sampled only in S_IDLE. A req arriving during S_ACCESS or S_DONE waits.
- S_ACCESS:
  - o_SRAM_ADDR = latched addr.
  - Write: o_SRAM_WE_N = 0, o_sram_dq_oe = 1, o_sram_wdata = latched wdata.
  - Read: WE_N = 1, dq_oe = 0.
  - The counter decrements each cycle. When it is 0, go to S_DONE.
  - For reads, i_sram_rdata is registered into the grantee's rdata on that final S_ACCESS edge.
- S_DONE:
  - The grantee's ack = 1 for exactly this cycle. The other port's rdata is untouched.
  - Address held. WE_N = 1. For writes, dq_oe and wdata stay asserted for this cycle (hold time).
  - Next state is S_IDLE.
- Latency: a req sampled in S_IDLE at cycle t gets its ack at cycle t+ACC_CYCLES+1. With default parameters that is 3 cycles, and each access occupies 4 cycles including the return to idle.
- Requester rule: deassert req on the edge that samples ack = 1. A req still high in the following S_IDLE cycle is treated as a new access.
- o_rdata holds its value until the next read completes for that port. Writes do not alter rdata.
- Outside S_ACCESS/S_DONE: WE_N = 1, dq_oe = 0, wdata = 0, address = 0. The DQ bus is never driven during a read, in idle, or at reset.
- Overrun:
  - On an i_frame_start cycle, if state != S_IDLE or any req is high, increment o_overrun_cnt.
  - The counter saturates at all-ones.
  - If i_clr_overrun coincides with an overrun event, clear wins and the result is 0.
  - Overrun does not alter arbitration.
- Changing a requester's addr/wdata/we_n while its access is in flight has no effect, because the values are latched.
- Reset mid-access: immediate return to S_IDLE with WE_N = 1 and dq_oe = 0 asynchronously. The pending ack is dropped and the requester must re-request.

Test Plan:
1. Reset, then D read: i_del_req=1, we_n=1, addr=0x00010, i_sram_rdata=0xBEEF -> addr 0x00010 for 3 cycles; o_del_ack pulses exactly 3 cycles after the req sample; o_del_rdata=0xBEEF; dq_oe stays 0; o_loop_ack stays 0.
2. D and L both request reads in the same cycle after reset -> D is served first (ack at t+3), L is served next (ack at t+7). Repeating with both requests gives D-L-D-L order.
3. L write: addr=0xFFFFF, wdata=0x8001 -> WE_N=0 for exactly 2 cycles; dq_oe=1 and o_sram_wdata=0x8001 for 3 cycles; WE_N rises one cycle before dq_oe falls; o_loop_rdata unchanged.
4. Overrun:
   - i_frame_start while in S_ACCESS -> o_overrun_cnt=1.
   - 300 such events -> count saturates at 255.
   - i_clr_overrun together with an event -> 0.
5. Assert i_rst_n=0 during the first cycle of a write access -> WE_N=1 and dq_oe=0 without waiting for a clock edge; no ack is issued; after release, state is S_IDLE and o_grant=00.
6. D holds req high continuously with L idle -> D is acked every 4 cycles; L then raises req -> L is served on the next S_IDLE cycle, before D.

Source files
------------

// File: rtl/sram_access_arbiter.sv
`timescale 1ns/1ps
// sram_access_arbiter
// Request/acknowledge arbiter that shares one external SRAM between the
// delay effect (port D) and the looper (port L). Round-robin on ties, fixed
// access length of ACC_CYCLES bus cycles followed by one hold/ack cycle, and
// a saturating count of sample frames that start while the SRAM is in use.
module sram_access_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int ACC_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_clr_overrun,
    input  logic              i_del_req,
    input  logic              i_del_we_n,
    input  logic [ADDR_W-1:0] i_del_addr,
    input  logic [DATA_W-1:0] i_del_wdata,
    output logic              o_del_ack,
    output logic [DATA_W-1:0] o_del_rdata,
    input  logic              i_loop_req,
    input  logic              i_loop_we_n,
    input  logic [ADDR_W-1:0] i_loop_addr,
    input  logic [DATA_W-1:0] i_loop_wdata,
    output logic              o_loop_ack,
    output logic [DATA_W-1:0] o_loop_rdata,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic              o_SRAM_WE_N,
    output logic              o_sram_dq_oe,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_busy,
    output logic [1:0]        o_grant,
    output logic [CNT_W-1:0]  o_overrun_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] ACC_LOAD = 4'(ACC_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                lat_we_n;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                last_grant;   // 0 = D, 1 = L; also the current owner once granted
    logic                any_req;
    logic                grant_l;

    // L wins when it is alone, or when both ask and D was served last
    assign any_req = i_del_req | i_loop_req;
    assign grant_l = i_loop_req & (~i_del_req | ~last_grant);

    // State register; reset drops any access in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: idle -> fixed-length access -> one ack cycle -> idle
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE:   if (any_req) state_nxt = S_ACCESS;
            S_ACCESS: if (cnt == '0) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request latch, round-robin memory, cycle counter and read-data capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            lat_we_n     <= 1'b1;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            last_grant   <= 1'b1;
            o_del_rdata  <= '0;
            o_loop_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        lat_we_n   <= grant_l ? i_loop_we_n  : i_del_we_n;
                        lat_addr   <= grant_l ? i_loop_addr  : i_del_addr;
                        lat_wdata  <= grant_l ? i_loop_wdata : i_del_wdata;
                        last_grant <= grant_l;
                        cnt        <= ACC_LOAD;
                    end
                end
                S_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else if (lat_we_n) begin
                        // Final access edge: the SRAM output has settled
                        if (last_grant) o_loop_rdata <= i_sram_rdata;
                        else            o_del_rdata  <= i_sram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating overrun count: a frame began while the SRAM was wanted or busy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun_cnt <= '0;
        end else if (i_clr_overrun) begin
            o_overrun_cnt <= '0;
        end else if (i_frame_start && (state != S_IDLE || any_req) &&
                     o_overrun_cnt != '1) begin
            o_overrun_cnt <= o_overrun_cnt + CNT_W'(1);
        end
    end

    // Bus outputs decoded from state, so reset parks the bus without a clock
    always_comb begin
        o_SRAM_ADDR  = '0;
        o_SRAM_WE_N  = 1'b1;
        o_sram_dq_oe = 1'b0;
        o_sram_wdata = '0;
        o_grant      = 2'b00;
        o_del_ack    = 1'b0;
        o_loop_ack   = 1'b0;
        o_busy       = (state != S_IDLE);
        case (state)
            S_ACCESS: begin
                o_SRAM_ADDR  = lat_addr;
                o_SRAM_WE_N  = lat_we_n;
                o_sram_dq_oe = ~lat_we_n;
                o_sram_wdata = lat_we_n ? '0 : lat_wdata;
                o_grant      = last_grant ? 2'b10 : 2'b01;
            end
            S_DONE: begin
                // WE_N already high; data stays driven one more cycle for hold
                o_SRAM_ADDR  = lat_addr;
                o_sram_dq_oe = ~lat_we_n;
                o_sram_wdata = lat_we_n ? '0 : lat_wdata;
                o_grant      = last_grant ? 2'b10 : 2'b01;
                o_del_ack    = ~last_grant;
                o_loop_ack   = last_grant;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
`timescale 1ns/1ps
// Testbench for sram_access_arbiter: directed scenarios with literal
// expectations, then random traffic, all cross-checked every cycle against a
// transaction-level model that tracks each access by its grant cycle number.
module tb_sram_access_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int ACC    = 2;
    localparam int CNT_W  = 8;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_frame_start;
    logic              i_clr_overrun;
    logic              i_del_req;
    logic              i_del_we_n;
    logic [ADDR_W-1:0] i_del_addr;
    logic [DATA_W-1:0] i_del_wdata;
    logic              o_del_ack;
    logic [DATA_W-1:0] o_del_rdata;
    logic              i_loop_req;
    logic              i_loop_we_n;
    logic [ADDR_W-1:0] i_loop_addr;
    logic [DATA_W-1:0] i_loop_wdata;
    logic              o_loop_ack;
    logic [DATA_W-1:0] o_loop_rdata;
    logic [ADDR_W-1:0] o_SRAM_ADDR;
    logic              o_SRAM_WE_N;
    logic              o_sram_dq_oe;
    logic [DATA_W-1:0] o_sram_wdata;
    logic [DATA_W-1:0] i_sram_rdata;
    logic              o_busy;
    logic [1:0]        o_grant;
    logic [CNT_W-1:0]  o_overrun_cnt;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    sram_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYCLES(ACC), .CNT_W(CNT_W)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_frame_start(i_frame_start), .i_clr_overrun(i_clr_overrun),
        .i_del_req(i_del_req), .i_del_we_n(i_del_we_n),
        .i_del_addr(i_del_addr), .i_del_wdata(i_del_wdata),
        .o_del_ack(o_del_ack), .o_del_rdata(o_del_rdata),
        .i_loop_req(i_loop_req), .i_loop_we_n(i_loop_we_n),
        .i_loop_addr(i_loop_addr), .i_loop_wdata(i_loop_wdata),
        .o_loop_ack(o_loop_ack), .o_loop_rdata(o_loop_rdata),
        .o_SRAM_ADDR(o_SRAM_ADDR), .o_SRAM_WE_N(o_SRAM_WE_N),
        .o_sram_dq_oe(o_sram_dq_oe), .o_sram_wdata(o_sram_wdata),
        .i_sram_rdata(i_sram_rdata),
        .o_busy(o_busy), .o_grant(o_grant), .o_overrun_cnt(o_overrun_cnt)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // An access granted in idle cycle m_start occupies the bus in cycles
    // m_start+1 .. m_start+ACC and acknowledges in cycle m_start+ACC+1.
    int                cyc      = 0;
    bit                m_act    = 1'b0;
    int                m_start  = 0;
    bit                m_owner  = 1'b0;
    bit                m_last   = 1'b1;
    logic              m_we_n   = 1'b1;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_wdata  = '0;
    logic [DATA_W-1:0] m_rd_d   = '0;
    logic [DATA_W-1:0] m_rd_l   = '0;
    int                m_ovr    = 0;

    function automatic bit pick_loop();
        if (i_del_req && i_loop_req) return !m_last;
        return i_loop_req;
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_act  <= 1'b0;
            m_last <= 1'b1;
            m_rd_d <= '0;
            m_rd_l <= '0;
            m_ovr  <= 0;
        end else begin
            if (!m_act) begin
                if (i_del_req || i_loop_req) begin
                    m_act   <= 1'b1;
                    m_start <= cyc;
                    m_owner <= pick_loop();
                    m_last  <= pick_loop();
                    m_we_n  <= pick_loop() ? i_loop_we_n  : i_del_we_n;
                    m_addr  <= pick_loop() ? i_loop_addr  : i_del_addr;
                    m_wdata <= pick_loop() ? i_loop_wdata : i_del_wdata;
                end
            end else begin
                if (cyc == m_start + ACC && m_we_n) begin
                    if (m_owner) m_rd_l <= i_sram_rdata;
                    else         m_rd_d <= i_sram_rdata;
                end
                if (cyc == m_start + ACC + 1) m_act <= 1'b0;
            end
            if (i_clr_overrun) m_ovr <= 0;
            else if (i_frame_start && (m_act || i_del_req || i_loop_req) && m_ovr != 255)
                m_ovr <= m_ovr + 1;
        end
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we_n;
        logic              oe;
        logic [DATA_W-1:0] wdata;
        logic              busy;
        logic [1:0]        grant;
        logic              dack;
        logic              lack;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e;
        int   k;
        bit   acc, done;
        k       = cyc - m_start;
        acc     = m_act && k >= 1 && k <= ACC;
        done    = m_act && k == ACC + 1;
        e.addr  = (acc || done) ? m_addr : '0;
        e.we_n  = acc ? m_we_n : 1'b1;
        e.oe    = (acc || done) && !m_we_n;
        e.wdata = e.oe ? m_wdata : '0;
        e.busy  = acc || done;
        e.grant = e.busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        e.dack  = done && !m_owner;
        e.lack  = done && m_owner;
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        e = expect_now();
        check("addr",      o_SRAM_ADDR,   e.addr);
        check("we_n",      o_SRAM_WE_N,   e.we_n);
        check("dq_oe",     o_sram_dq_oe,  e.oe);
        check("wdata",     o_sram_wdata,  e.wdata);
        check("busy",      o_busy,        e.busy);
        check("grant",     o_grant,       e.grant);
        check("del_ack",   o_del_ack,     e.dack);
        check("loop_ack",  o_loop_ack,    e.lack);
        check("del_rdata", o_del_rdata,   m_rd_d);
        check("loop_rdata",o_loop_rdata,  m_rd_l);
        check("overrun",   o_overrun_cnt, m_ovr);
    endtask

    always @(negedge i_clk) if (cmp_en) compare_all();

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        step();
    endtask

    // Hold req until the port's ack is seen, then drop it on the sampling edge
    task automatic release_on_ack(input bit port);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge i_clk);
            seen = port ? o_loop_ack : o_del_ack;
            step();
            if (seen) begin
                if (port) i_loop_req = 1'b0;
                else      i_del_req  = 1'b0;
            end
        end
        check("ack_timeout", seen, 1);
    endtask

    initial begin
        i_rst_n = 1'b0;  i_frame_start = 1'b0; i_clr_overrun = 1'b0;
        i_del_req = 1'b0;  i_del_we_n = 1'b1;  i_del_addr = '0;  i_del_wdata = '0;
        i_loop_req = 1'b0; i_loop_we_n = 1'b1; i_loop_addr = '0; i_loop_wdata = '0;
        i_sram_rdata = '0;
        step();
        cmp_en = 1'b1;
        do_reset();
        check("rst_grant", o_grant, 0);
        check("rst_we_n", o_SRAM_WE_N, 1);
        check("rst_ovr", o_overrun_cnt, 0);

        // 1: single D read
        begin
            int an;
            an = -1;
            i_del_req = 1'b1; i_del_we_n = 1'b1; i_del_addr = 20'h00010;
            i_sram_rdata = 16'hBEEF;
            for (int n = 0; n < 8 && an < 0; n++) begin
                logic da;
                @(negedge i_clk);
                da = o_del_ack;
                if (da) an = n;
                if (n >= 1 && n <= 3) check("t1_addr", o_SRAM_ADDR, 20'h00010);
                check("t1_oe", o_sram_dq_oe, 0);
                check("t1_lack", o_loop_ack, 0);
                step();
                if (da) i_del_req = 1'b0;
            end
            check("t1_latency", an, 3);
            check("t1_rdata", o_del_rdata, 16'hBEEF);
        end

        // 2: simultaneous reads after reset, twice -> D, L, D, L
        do_reset();
        i_sram_rdata = 16'h1234;
        for (int r = 0; r < 2; r++) begin
            int dn, ln;
            dn = -1; ln = -1;
            i_del_req = 1'b1;  i_del_we_n = 1'b1;  i_del_addr = 20'h00100;
            i_loop_req = 1'b1; i_loop_we_n = 1'b1; i_loop_addr = 20'h00200;
            for (int n = 0; n < 16 && (dn < 0 || ln < 0); n++) begin
                logic da, la;
                @(negedge i_clk);
                da = o_del_ack; la = o_loop_ack;
                if (da) dn = n;
                if (la) ln = n;
                step();
                if (da) i_del_req = 1'b0;
                if (la) i_loop_req = 1'b0;
            end
            check("t2_d_ack", dn, 3);
            check("t2_l_ack", ln, 7);
        end
        check("t2_lrdata", o_loop_rdata, 16'h1234);

        // 3: L write to the top address
        begin
            int we_cnt, oe_cnt, last_we, last_oe, an;
            we_cnt = 0; oe_cnt = 0; last_we = -1; last_oe = -1; an = -1;
            i_loop_req = 1'b1; i_loop_we_n = 1'b0;
            i_loop_addr = 20'hFFFFF; i_loop_wdata = 16'h8001;
            for (int n = 0; n < 8; n++) begin
                logic la;
                @(negedge i_clk);
                la = o_loop_ack;
                if (la) an = n;
                if (!o_SRAM_WE_N) begin we_cnt++; last_we = n; end
                if (o_sram_dq_oe && o_sram_wdata == 16'h8001) begin oe_cnt++; last_oe = n; end
                step();
                if (la) i_loop_req = 1'b0;
            end
            i_loop_we_n = 1'b1;
            check("t3_we_cycles", we_cnt, 2);
            check("t3_oe_cycles", oe_cnt, 3);
            check("t3_we_before_oe", last_oe - last_we, 1);
            check("t3_ack", an, 3);
            check("t3_lrdata_kept", o_loop_rdata, 16'h1234);
        end

        // 4: overrun counting, saturation, clear priority
        i_del_req = 1'b1; i_del_we_n = 1'b1;
        step();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        @(negedge i_clk);
        check("t4_one", o_overrun_cnt, 1);
        for (int i = 0; i < 300; i++) begin
            step(); i_frame_start = 1'b1;
            step(); i_frame_start = 1'b0;
        end
        @(negedge i_clk);
        check("t4_sat", o_overrun_cnt, 255);
        step(); i_frame_start = 1'b1; i_clr_overrun = 1'b1;
        step(); i_frame_start = 1'b0; i_clr_overrun = 1'b0;
        @(negedge i_clk);
        check("t4_clr", o_overrun_cnt, 0);
        release_on_ack(1'b0);

        // 5: asynchronous reset in the first cycle of a write
        i_del_req = 1'b1; i_del_we_n = 1'b0; i_del_addr = 20'h00ABC; i_del_wdata = 16'h5A5A;
        step();
        #2;
        check("t5_we_low", o_SRAM_WE_N, 0);
        i_rst_n = 1'b0;
        #1;
        check("t5_we_async", o_SRAM_WE_N, 1);
        check("t5_oe_async", o_sram_dq_oe, 0);
        check("t5_grant_async", o_grant, 0);
        i_del_req = 1'b0; i_del_we_n = 1'b1;
        step(); step();
        i_rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge i_clk);
            check("t5_no_ack", o_del_ack, 0);
        end
        check("t5_grant_idle", o_grant, 0);
        check("t5_idle", o_busy, 0);

        // 6: D streams continuously, then L cuts in at the next idle cycle
        begin
            int acks[3];
            int k, dm1, dm2, lm;
            k = 0; dm1 = -1; dm2 = -1; lm = -1;
            step();
            i_del_req = 1'b1; i_del_we_n = 1'b1; i_del_addr = 20'h00042;
            for (int n = 0; n < 13; n++) begin
                @(negedge i_clk);
                if (o_del_ack && k < 3) begin acks[k] = n; k++; end
                if (n < 12) step();
            end
            check("t6_first", acks[0], 3);
            check("t6_period1", acks[1] - acks[0], 4);
            check("t6_period2", acks[2] - acks[1], 4);
            step();
            i_loop_req = 1'b1; i_loop_we_n = 1'b1; i_loop_addr = 20'h00077;
            for (int m = 0; m < 12; m++) begin
                logic da, la;
                @(negedge i_clk);
                da = o_del_ack; la = o_loop_ack;
                if (la) lm = m;
                if (da && dm1 < 0) dm1 = m;
                else if (da && dm2 < 0) dm2 = m;
                step();
                if (la) i_loop_req = 1'b0;
            end
            check("t6_d_inflight", dm1, 2);
            check("t6_l_next", lm, 6);
            check("t6_d_after", dm2, 10);
            release_on_ack(1'b0);
        end

        // Random traffic under the requester handshake
        begin
            bit dp, lp;
            dp = 1'b0; lp = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                logic da, la;
                @(negedge i_clk);
                da = o_del_ack; la = o_loop_ack;
                step();
                if (da) dp = 1'b0;
                if (la) lp = 1'b0;
                if (!dp) begin i_del_req  = ($urandom_range(0, 2) == 0); dp = i_del_req;  end
                if (!lp) begin i_loop_req = ($urandom_range(0, 2) == 0); lp = i_loop_req; end
                i_del_we_n    = $urandom_range(0, 1);
                i_loop_we_n   = $urandom_range(0, 1);
                i_del_addr    = ADDR_W'($urandom);
                i_loop_addr   = ADDR_W'($urandom);
                i_del_wdata   = DATA_W'($urandom);
                i_loop_wdata  = DATA_W'($urandom);
                i_sram_rdata  = DATA_W'($urandom);
                i_frame_start = ($urandom_range(0, 15) == 0);
                i_clr_overrun = ($urandom_range(0, 63) == 0);
            end
            i_frame_start = 1'b0;
            i_clr_overrun = 1'b0;
            if (dp) release_on_ack(1'b0);
            if (lp) release_on_ack(1'b1);
        end

        repeat (4) step();
        @(negedge i_clk);
        check("end_idle", o_busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
